parking_fee_accumulator: RTL and testbench

//   Parametrised, clocked successor to the combinational tariff schematic. It supports
//   NUM_CLIENTS client classes, each with its own per-unit rate. Button presses are

---
 rtl/parking_fee_accumulator_if.sv | 21 ++
 rtl/parking_fee_accumulator.sv | 156 +++++++++++++++
 tb/tb_parking_fee_accumulator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/parking_fee_accumulator_if.sv
// Payment handshake between the fee accumulator and the display/payment stage.
// The fee is held on ValueToPay while PayValid is high, until the payment stage answers with PayAck.
interface parking_fee_accumulator_if #(
   parameter int VALUE_W = 6
);
   logic [VALUE_W-1:0] ValueToPay;
   logic               PayValid;
   logic               PayAck;

   modport master (
      output ValueToPay,
      output PayValid,
      input  PayAck
   );

   modport slave (
      input  ValueToPay,
      input  PayValid,
      output PayAck
   );
endinterface

// File: rtl/parking_fee_accumulator.sv
// Clocked parking tariff: edge-detected duration buttons build up saturating 30-minute units per client class.
// On Confirm the fee (units x client rate, clamped to the output width) is offered on the payment handshake.
module parking_fee_accumulator #(
   parameter int                             NUM_CLIENTS  = 2,
   parameter int                             UNIT_W       = 4,
   parameter int                             MAX_UNITS    = 8,
   parameter int                             RATE_W       = 3,
   parameter logic [NUM_CLIENTS*RATE_W-1:0]  CLIENT_RATES = {3'd2, 3'd1},
   parameter int                             VALUE_W      = 6
) (
   input  logic                    Clk,
   input  logic                    ResetN,
   input  logic [NUM_CLIENTS-1:0]  ClientSel,
   input  logic                    Button30Min,
   input  logic                    Button1Hour,
   input  logic                    Button2Hours,
   input  logic                    Confirm,
   input  logic                    Cancel,
   parking_fee_accumulator_if.master pay,
   output logic [UNIT_W-1:0]       Units,
   output logic                    SelError
);

   localparam int IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int SUM_W  = UNIT_W + 3;
   localparam int PROD_W = UNIT_W + RATE_W;
   localparam int CMP_W  = (PROD_W > VALUE_W) ? PROD_W : VALUE_W;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      CALC,
      PAY
   } StateT;

   StateT              state, stateNext;
   logic [IDX_W-1:0]   clientIdx, clientIdxNext;
   logic [UNIT_W-1:0]  unitsReg, unitsNext;
   logic [VALUE_W-1:0] valueReg, valueNext;
   logic               payValidReg, payValidNext;
   logic               selErrReg, selErrNext;

   logic               b30Q, b1hQ, b2hQ, confirmQ;
   logic               rise30, rise1h, rise2h, riseConfirm;
   logic [2:0]         addUnits;
   logic [SUM_W-1:0]   sumWide;
   logic [UNIT_W-1:0]  satUnits;
   logic               selOneHot;
   logic [IDX_W-1:0]   selIdx;
   logic [RATE_W-1:0]  rate;
   logic [PROD_W-1:0]  prod;
   logic [CMP_W-1:0]   prodCmp, maxCmp;
   logic [VALUE_W-1:0] feeSat;

   // Previous input levels are captured even in reset, so a button held through reset never looks like a press.
   always_ff @(posedge Clk) begin
      b30Q     <= Button30Min;
      b1hQ     <= Button1Hour;
      b2hQ     <= Button2Hours;
      confirmQ <= Confirm;
   end

   assign rise30      = Button30Min  & ~b30Q;
   assign rise1h      = Button1Hour  & ~b1hQ;
   assign rise2h      = Button2Hours & ~b2hQ;
   assign riseConfirm = Confirm      & ~confirmQ;

   // Bit weights 1/2/4 make the concatenation the unit increment directly.
   always_comb begin
      addUnits  = {rise2h, rise1h, rise30};
      sumWide   = SUM_W'(unitsReg) + SUM_W'(addUnits);
      satUnits  = (sumWide > SUM_W'(MAX_UNITS)) ? UNIT_W'(MAX_UNITS) : UNIT_W'(sumWide);
      selOneHot = (ClientSel != '0) &&
                  ((ClientSel & (ClientSel - NUM_CLIENTS'(1))) == '0);
      selIdx    = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (ClientSel[i]) selIdx = IDX_W'(i);
      end
      rate = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (clientIdx == IDX_W'(i)) rate = CLIENT_RATES[i*RATE_W +: RATE_W];
      end
      prod    = PROD_W'(unitsReg) * PROD_W'(rate);
      prodCmp = CMP_W'(prod);
      maxCmp  = CMP_W'({VALUE_W{1'b1}});
      feeSat  = (prodCmp > maxCmp) ? VALUE_W'(maxCmp) : VALUE_W'(prodCmp);
   end

   // Transaction sequencing; Cancel wins over everything else sampled while accumulating.
   always_comb begin
      stateNext     = state;
      clientIdxNext = clientIdx;
      unitsNext     = unitsReg;
      valueNext     = valueReg;
      payValidNext  = payValidReg;
      selErrNext    = 1'b0;
      unique case (state)
         IDLE: begin
            if (selOneHot) begin
               clientIdxNext = selIdx;
               unitsNext     = '0;
               stateNext     = ACCUM;
            end else if (ClientSel != '0) begin
               selErrNext = 1'b1;
            end
         end
         ACCUM: begin
            if (Cancel) begin
               unitsNext = '0;
               stateNext = IDLE;
            end else begin
               unitsNext = satUnits;
               if (riseConfirm && (satUnits != '0)) stateNext = CALC;
            end
         end
         CALC: begin
            valueNext    = feeSat;
            payValidNext = 1'b1;
            stateNext    = PAY;
         end
         PAY: begin
            if (pay.PayAck) begin
               valueNext    = '0;
               payValidNext = 1'b0;
               unitsNext    = '0;
               stateNext    = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state       <= IDLE;
         clientIdx   <= '0;
         unitsReg    <= '0;
         valueReg    <= '0;
         payValidReg <= 1'b0;
         selErrReg   <= 1'b0;
      end else begin
         state       <= stateNext;
         clientIdx   <= clientIdxNext;
         unitsReg    <= unitsNext;
         valueReg    <= valueNext;
         payValidReg <= payValidNext;
         selErrReg   <= selErrNext;
      end
   end

   assign pay.ValueToPay = valueReg;
   assign pay.PayValid   = payValidReg;
   assign Units          = unitsReg;
   assign SelError       = selErrReg;

endmodule

// File: tb/tb_parking_fee_accumulator.sv
// Directed bench for parking_fee_accumulator: a vector table for the two main transactions,
// then hand-written sequences for fee clamping, selection errors, cancel and mid-payment reset.
module tb_parking_fee_accumulator;

   logic       Clk;
   logic       ResetN;
   logic [1:0] ClientSel;
   logic       Button30Min, Button1Hour, Button2Hours;
   logic       Confirm, Cancel, payAck;
   logic [3:0] Units, unitsNarrow;
   logic       SelError, selErrNarrow;

   int total = 0;
   int bad   = 0;

   parking_fee_accumulator_if #(.VALUE_W(6)) payBus ();
   parking_fee_accumulator_if #(.VALUE_W(4)) payNarrow ();

   assign payBus.PayAck    = payAck;
   assign payNarrow.PayAck = payAck;

   parking_fee_accumulator #(.VALUE_W(6)) dut (
      .Clk          (Clk),
      .ResetN       (ResetN),
      .ClientSel    (ClientSel),
      .Button30Min  (Button30Min),
      .Button1Hour  (Button1Hour),
      .Button2Hours (Button2Hours),
      .Confirm      (Confirm),
      .Cancel       (Cancel),
      .pay          (payBus),
      .Units        (Units),
      .SelError     (SelError)
   );

   parking_fee_accumulator #(.VALUE_W(4)) dutNarrow (
      .Clk          (Clk),
      .ResetN       (ResetN),
      .ClientSel    (ClientSel),
      .Button30Min  (Button30Min),
      .Button1Hour  (Button1Hour),
      .Button2Hours (Button2Hours),
      .Confirm      (Confirm),
      .Cancel       (Cancel),
      .pay          (payNarrow),
      .Units        (unitsNarrow),
      .SelError     (selErrNarrow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string      name;
      logic [1:0] sel;
      logic       b30, b1h, b2h, conf, canc, ack;
      int         expUnits;
      int         expValid;
      int         expValue;
   } VecT;

   VecT vecs[$];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input VecT v);
      ClientSel    = v.sel;
      Button30Min  = v.b30;
      Button1Hour  = v.b1h;
      Button2Hours = v.b2h;
      Confirm      = v.conf;
      Cancel       = v.canc;
      payAck       = v.ack;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic setIdle();
      ClientSel = 2'b00; Button30Min = 0; Button1Hour = 0; Button2Hours = 0;
      Confirm = 0; Cancel = 0; payAck = 0;
   endtask

   initial begin
      // name, sel, b30, b1h, b2h, confirm, cancel, ack, units, valid, value
      vecs.push_back(VecT'{"t1_select",  2'b10, 0,0,0, 0,0,0, 0,0,0});
      vecs.push_back(VecT'{"t1_30min",   2'b00, 1,0,0, 0,0,0, 1,0,0});
      vecs.push_back(VecT'{"t1_rel_a",   2'b00, 0,0,0, 0,0,0, 1,0,0});
      vecs.push_back(VecT'{"t1_1hour",   2'b00, 0,1,0, 0,0,0, 3,0,0});
      vecs.push_back(VecT'{"t1_rel_b",   2'b00, 0,0,0, 0,0,0, 3,0,0});
      vecs.push_back(VecT'{"t1_2hours",  2'b00, 0,0,1, 0,0,0, 7,0,0});
      vecs.push_back(VecT'{"t1_rel_c",   2'b00, 0,0,0, 0,0,0, 7,0,0});
      vecs.push_back(VecT'{"t1_confirm", 2'b00, 0,0,0, 1,0,0, 7,0,0});
      vecs.push_back(VecT'{"t1_calc",    2'b00, 0,0,0, 1,0,0, 7,1,14});
      vecs.push_back(VecT'{"t1_payhold", 2'b01, 1,0,0, 0,0,0, 7,1,14});
      vecs.push_back(VecT'{"t1_ack",     2'b00, 0,0,0, 0,0,1, 0,0,0});
      vecs.push_back(VecT'{"t1_idle",    2'b00, 0,0,0, 0,0,0, 0,0,0});
      vecs.push_back(VecT'{"t2_select",  2'b01, 0,0,0, 0,0,0, 0,0,0});
      vecs.push_back(VecT'{"t2_2h_a",    2'b00, 0,0,1, 0,0,0, 4,0,0});
      vecs.push_back(VecT'{"t2_ackaccum",2'b00, 0,0,0, 0,0,1, 4,0,0});
      vecs.push_back(VecT'{"t2_2h_b",    2'b00, 0,0,1, 0,0,0, 8,0,0});
      vecs.push_back(VecT'{"t2_rel_a",   2'b00, 0,0,0, 0,0,0, 8,0,0});
      vecs.push_back(VecT'{"t2_2h_sat",  2'b00, 0,0,1, 0,0,0, 8,0,0});
      vecs.push_back(VecT'{"t2_rel_b",   2'b00, 0,0,0, 0,0,0, 8,0,0});
      vecs.push_back(VecT'{"t2_confirm", 2'b00, 0,0,0, 1,0,0, 8,0,0});
      vecs.push_back(VecT'{"t2_calc",    2'b00, 0,0,0, 0,0,0, 8,1,8});
      vecs.push_back(VecT'{"t2_ack",     2'b00, 0,0,0, 0,0,1, 0,0,0});

      setIdle();
      ResetN = 1'b0;
      tick();
      tick();
      checkOutput("reset_units", int'(Units), 0);
      checkOutput("reset_valid", int'(payBus.PayValid), 0);
      checkOutput("reset_value", int'(payBus.ValueToPay), 0);
      checkOutput("reset_selerr", int'(SelError), 0);
      ResetN = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput({vecs[i].name, "_units"}, int'(Units), vecs[i].expUnits);
         checkOutput({vecs[i].name, "_valid"}, int'(payBus.PayValid), vecs[i].expValid);
         checkOutput({vecs[i].name, "_value"}, int'(payBus.ValueToPay), vecs[i].expValue);
      end
      setIdle();
      tick();

      // T3: client1 with 8 units gives 16, which the 4-bit fee output clamps to 15
      ClientSel = 2'b10; tick(); ClientSel = 2'b00;
      Button2Hours = 1; tick(); Button2Hours = 0; tick();
      Button2Hours = 1; tick(); Button2Hours = 0; tick();
      checkOutput("t3_units", int'(Units), 8);
      Confirm = 1; tick(); Confirm = 0; tick();
      checkOutput("t3_wide_value", int'(payBus.ValueToPay), 16);
      checkOutput("t3_narrow_valid", int'(payNarrow.PayValid), 1);
      checkOutput("t3_narrow_value", int'(payNarrow.ValueToPay), 15);
      payAck = 1; tick(); payAck = 0;
      checkOutput("t3_ack_valid", int'(payNarrow.PayValid), 0);
      tick();

      // T4: multi-hot select errors, then an empty confirm is ignored
      ClientSel = 2'b11; tick();
      checkOutput("t4_selerr_pulse", int'(SelError), 1);
      checkOutput("t4_units_idle", int'(Units), 0);
      ClientSel = 2'b00; tick();
      checkOutput("t4_selerr_clear", int'(SelError), 0);
      ClientSel = 2'b01; tick(); ClientSel = 2'b00;
      checkOutput("t4_selerr_onehot", int'(SelError), 0);
      Confirm = 1; tick(); Confirm = 0; tick();
      checkOutput("t4_empty_valid_a", int'(payBus.PayValid), 0);
      tick();
      checkOutput("t4_empty_valid_b", int'(payBus.PayValid), 0);
      Button30Min = 1; tick(); Button30Min = 0;
      checkOutput("t4_still_accum", int'(Units), 1);
      Cancel = 1; tick(); Cancel = 0; tick();
      checkOutput("t4_cancel_units", int'(Units), 0);

      // T5: Cancel together with a Confirm rise and a button press discards the transaction
      ClientSel = 2'b01; tick(); ClientSel = 2'b00;
      Button30Min = 1; tick(); Button30Min = 0; tick();
      Button1Hour = 1; tick(); Button1Hour = 0; tick();
      checkOutput("t5_units", int'(Units), 3);
      Confirm = 1; Cancel = 1; Button2Hours = 1; tick();
      Confirm = 0; Cancel = 0; Button2Hours = 0;
      checkOutput("t5_cancel_units", int'(Units), 0);
      tick();
      checkOutput("t5_valid_a", int'(payBus.PayValid), 0);
      tick();
      checkOutput("t5_valid_b", int'(payBus.PayValid), 0);
      ClientSel = 2'b11; tick(); ClientSel = 2'b00;
      checkOutput("t5_back_idle", int'(SelError), 1);
      tick();

      // T6: reset during PAY drops the fee; a button held across reset adds nothing
      ClientSel = 2'b10; tick(); ClientSel = 2'b00;
      Button30Min = 1; tick(); Button30Min = 0; tick();
      Confirm = 1; tick(); Confirm = 0; tick();
      checkOutput("t6_pay_valid", int'(payBus.PayValid), 1);
      checkOutput("t6_pay_value", int'(payBus.ValueToPay), 2);
      ResetN = 0; Button2Hours = 1; tick();
      checkOutput("t6_rst_valid", int'(payBus.PayValid), 0);
      checkOutput("t6_rst_value", int'(payBus.ValueToPay), 0);
      checkOutput("t6_rst_units", int'(Units), 0);
      tick();
      ResetN = 1; ClientSel = 2'b01; tick(); ClientSel = 2'b00;
      checkOutput("t6_held_a", int'(Units), 0);
      tick();
      checkOutput("t6_held_b", int'(Units), 0);
      checkOutput("t6_no_valid", int'(payBus.PayValid), 0);
      Button2Hours = 0; tick();
      Button2Hours = 1; tick(); Button2Hours = 0;
      checkOutput("t6_fresh_press", int'(Units), 4);
      Cancel = 1; tick(); Cancel = 0; tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
